// File: rtl/booth4_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
package booth4_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Select fields of one recoded digit: magnitude one or two, optional negate.
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_sel_t;

  function automatic booth_sel_t booth_decode(input logic [2:0] grp);
    booth_sel_t sel;
    sel.neg = grp[2] & ~(grp[1] & grp[0]);
    sel.one = grp[1] ^ grp[0];
    sel.two = (grp == 3'b011) | (grp == 3'b100);
    return sel;
  endfunction

  // One guard digit on top so zero-extended unsigned operands recode exactly.
  function automatic int unsigned n_dig(input int unsigned width);
    return width / 2 + 1;
  endfunction

  function automatic int unsigned n_iter(input int unsigned digits, input int unsigned per_cycle);
    return (digits + per_cycle - 1) / per_cycle;
  endfunction

endpackage

// File: rtl/booth4_digit_pp.sv
// One Booth digit: recodes a 3-bit multiplier group into a signed multiple of A.
module booth4_digit_pp
  import booth4_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [2:0]       grp,
  input  logic [WIDTH+1:0] a_ext,
  output logic [WIDTH+1:0] pp_c
);

  localparam int unsigned PPW = WIDTH + 2;

  booth_sel_t     sel;
  logic [PPW-1:0] mag;

  always_comb begin
    sel = booth_decode(grp);
    mag = '0;
    if (sel.one) begin
      mag = a_ext;
    end else if (sel.two) begin
      mag = {a_ext[PPW-2:0], 1'b0};
    end
    pp_c = sel.neg ? PPW'(~mag + PPW'(1)) : mag;
  end

endmodule

// File: rtl/booth4_seq_mult.sv
// Iterative radix-4 Booth multiplier retiring PP_PER_CYCLE digits per busy cycle,
// with valid/ready handshakes on operands and product.
module booth4_seq_mult
  import booth4_pkg::*;
#(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned PP_PER_CYCLE = 3
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A_NUM,
  input  logic [WIDTH-1:0]     B_NUM,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   PRODUCT
);

  localparam int unsigned N_DIG = n_dig(WIDTH);
  localparam int unsigned ITER  = n_iter(N_DIG, PP_PER_CYCLE);
  localparam int unsigned EXT   = 2 * ITER * PP_PER_CYCLE;
  localparam int unsigned STEP  = 2 * PP_PER_CYCLE;
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned AW    = WIDTH + 2;
  localparam int unsigned CNT_W = $clog2(ITER + 1);

  state_t           state;
  logic [AW-1:0]    a_ext;
  logic [EXT:0]     b_sh;     // bit 0 is the implicit B[-1]
  logic [PW-1:0]    acc;
  logic [CNT_W-1:0] iter_cnt;

  logic [AW-1:0]    pp_c [PP_PER_CYCLE];
  logic [PW-1:0]    pp_ext_c;
  logic [PW-1:0]    sum_c;
  int unsigned      sh_c;

  for (genvar j = 0; j < PP_PER_CYCLE; j++) begin : g_pp
    booth4_digit_pp #(.WIDTH(WIDTH)) u_pp (
      .grp  (b_sh[2*j+2 : 2*j]),
      .a_ext(a_ext),
      .pp_c (pp_c[j])
    );
  end

  // Chain of adders folding this cycle's partial products into the accumulator.
  always_comb begin
    sum_c    = acc;
    pp_ext_c = '0;
    sh_c     = 0;
    for (int unsigned j = 0; j < PP_PER_CYCLE; j++) begin
      pp_ext_c = {{(PW-AW){pp_c[j][AW-1]}}, pp_c[j]};
      sh_c     = STEP * 32'(iter_cnt) + 2 * j;
      sum_c    = sum_c + (pp_ext_c << sh_c);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      PRODUCT   <= '0;
      acc       <= '0;
      iter_cnt  <= '0;
      a_ext     <= '0;
      b_sh      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_ext    <= {{2{signed_mode & A_NUM[WIDTH-1]}}, A_NUM};
            b_sh     <= {{(EXT-WIDTH){signed_mode & B_NUM[WIDTH-1]}}, B_NUM, 1'b0};
            acc      <= '0;
            iter_cnt <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          acc      <= sum_c;
          b_sh     <= b_sh >> STEP;
          iter_cnt <= iter_cnt + CNT_W'(1);
          if (iter_cnt == CNT_W'(ITER - 1)) begin
            PRODUCT   <= sum_c;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth4_seq_mult.sv
// Scoreboard bench for booth4_seq_mult over three configurations run side by side:
// (16,3) default, (16,1) with nine busy cycles, and (8,3).
module tb_booth4_seq_mult;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc      = 0;
  logic        clk      = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int unsigned W    = (g == 2) ? 8 : 16;
    localparam int unsigned PP   = (g == 1) ? 1 : 3;
    localparam int unsigned ITER = (W / 2 + 1 + PP - 1) / PP;

    logic           rst_n       = 1'b1;
    logic           in_valid    = 1'b0;
    logic           signed_mode = 1'b0;
    logic           out_ready   = 1'b1;
    logic           fin         = 1'b0;
    logic [W-1:0]   a_num       = '0;
    logic [W-1:0]   b_num       = '0;
    logic           in_ready;
    logic           out_valid;
    logic [2*W-1:0] product;
    logic [2*W-1:0] sb [$];
    int unsigned    n_acc   = 0;
    int unsigned    n_sent  = 0;
    int unsigned    acc_cyc = 0;

    booth4_seq_mult #(.WIDTH(W), .PP_PER_CYCLE(PP)) dut (
      .sys_clk    (clk),
      .sys_rst_n  (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .A_NUM      (a_num),
      .B_NUM      (b_num),
      .signed_mode(signed_mode),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .PRODUCT    (product)
    );

    function automatic string tg(input string s);
      return $sformatf("c%0d_%s", g, s);
    endfunction

    // Reference: extend both operands to 2W bits and multiply modulo 2^(2W).
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic s);
      logic [2*W-1:0] ea;
      logic [2*W-1:0] eb;
      ea = {{W{s & a[W-1]}}, a};
      eb = {{W{s & b[W-1]}}, b};
      return ea * eb;
    endfunction

    function automatic logic [W-1:0] opnd(input int code);
      case (code)
        1:       return {1'b1, {(W-1){1'b0}}};
        2:       return '1;
        3:       return W'(9);
        4:       return W'(25);
        5:       return W'($urandom);
        default: return '0;
      endcase
    endfunction

    always @(negedge clk) begin
      if (rst_n && in_valid && in_ready) n_acc++;
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) check(tg("sb_nonempty_at_output"), 64'(sb.size()), 64'd1);
        else check(tg("product"), 64'(product), 64'(sb.pop_front()));
      end
    end

    // Present one operand pair, wait (bounded) for acceptance; returns just after the accept edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [2*W-1:0] exp, input bit push, input bit rnd);
      int k;
      a_num = a; b_num = b; signed_mode = s; in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 400) begin
        @(posedge clk); #1;
        if (rnd) out_ready = ($urandom_range(0, 3) != 0);
        k++;
      end
      if (!in_ready) check(tg("accept_wait"), 64'(in_ready), 64'd1);
      if (push) sb.push_back(exp);
      n_sent++;
      @(posedge clk); #1;
      acc_cyc = cyc;
    endtask

    initial begin : drive
      logic [31:0]    exp16 [8];
      int             ca [8];
      int             cb [8];
      logic           sm [8];
      int unsigned    ts [3];
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic           s;
      logic [2*W-1:0] e;
      int             n;

      #1 rst_n = 1'b0;
      #1;
      check(tg("rst_in_ready"), 64'(in_ready), 64'd1);
      check(tg("rst_out_valid"), 64'(out_valid), 64'd0);
      check(tg("rst_product"), 64'(product), 64'd0);
      @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed corner vectors; literal results for the 16-bit configurations.
      ca = '{1, 1, 2, 2, 1, 3, 0, 0};
      cb = '{4, 4, 2, 2, 1, 3, 5, 5};
      sm = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      exp16 = '{32'hFFF38000, 32'h000C8000, 32'hFFFE0001, 32'h00000001,
                32'h40000000, 32'h00000051, 32'h00000000, 32'h00000000};
      for (int i = 0; i < 8; i++) begin
        a = opnd(ca[i]); b = opnd(cb[i]);
        e = (W == 16) ? (2*W)'(exp16[i]) : ref_mul(a, b, sm[i]);
        send(a, b, sm[i], e, 1'b1, 1'b0);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        check(tg("latency"), 64'(n), 64'(ITER));
        @(posedge clk); #1;
      end

      // Backpressure: result and flags hold while inputs wander.
      out_ready = 1'b0;
      a = W'($urandom); b = W'($urandom); e = ref_mul(a, b, 1'b1);
      send(a, b, 1'b1, e, 1'b1, 1'b0);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
      for (int i = 0; i < 10; i++) begin
        check(tg("bp_product"), 64'(product), 64'(e));
        check(tg("bp_out_valid"), 64'(out_valid), 64'd1);
        check(tg("bp_in_ready"), 64'(in_ready), 64'd0);
        a_num = W'($urandom); b_num = W'($urandom); signed_mode = ~signed_mode;
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check(tg("bp_release_in_ready"), 64'(in_ready), 64'd1);
      check(tg("bp_release_out_valid"), 64'(out_valid), 64'd0);

      // Back-to-back with in_valid held high.
      for (int i = 0; i < 3; i++) begin
        a = W'($urandom); b = W'($urandom); s = 1'($urandom);
        send(a, b, s, ref_mul(a, b, s), 1'b1, 1'b0);
        ts[i] = acc_cyc;
      end
      in_valid = 1'b0;
      check(tg("b2b_interval0"), 64'(ts[1] - ts[0]), 64'(ITER + 2));
      check(tg("b2b_interval1"), 64'(ts[2] - ts[1]), 64'(ITER + 2));
      repeat (ITER + 3) begin @(posedge clk); #1; end

      // Reset during BUSY aborts the transaction; nothing is pushed for it.
      a = W'($urandom); b = W'($urandom);
      send(a, b, 1'b0, '0, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0; in_valid = 1'b0;
      #1;
      check(tg("abort_out_valid"), 64'(out_valid), 64'd0);
      check(tg("abort_in_ready"), 64'(in_ready), 64'd1);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check(tg("post_abort_in_ready"), 64'(in_ready), 64'd1);
      check(tg("post_abort_out_valid"), 64'(out_valid), 64'd0);
      repeat (ITER + 4) begin @(posedge clk); #1; end

      // Random vectors with extreme-value bias and random output stalls.
      for (int i = 0; i < 1000; i++) begin
        case ($urandom_range(0, 7))
          0: a = opnd(1); 1: a = opnd(2); 2: a = '0; default: a = W'($urandom);
        endcase
        case ($urandom_range(0, 7))
          0: b = opnd(1); 1: b = opnd(2); 2: b = '0; default: b = W'($urandom);
        endcase
        s = 1'($urandom);
        send(a, b, s, ref_mul(a, b, s), 1'b1, 1'b1);
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      n = 0;
      while (sb.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
      check(tg("sb_drained"), 64'(sb.size()), 64'd0);
      check(tg("accept_count"), 64'(n_acc), 64'(n_sent));
      fin = 1'b1;
    end
  end

  initial begin : top_ctl
    int k;
    k = 0;
    while (!(cfg[0].fin && cfg[1].fin && cfg[2].fin) && k < 90000) begin
      @(posedge clk);
      k++;
    end
    if (!(cfg[0].fin && cfg[1].fin && cfg[2].fin))
      check("run_complete", 64'({cfg[2].fin, cfg[1].fin, cfg[0].fin}), 64'h7);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
